// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module : alu_pkg
// Brief  : Shared ALU opcode encoding and request bundle.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam int unsigned ALU_OP_MAX = 9;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } alu_req_t;

endpackage

`default_nettype wire

// File: rtl/alu_share_arb_alu.sv
//------------------------------------------------------------------------------
// Module : alu_share_arb_alu
// Brief  : Combinational 32-bit ALU; undefined opcodes yield zero.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_share_arb_alu
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALU_op,
    output logic [31:0] out
);

    logic [4:0] w_shamt;
    assign w_shamt = B[4:0];

    always_comb begin
        out = 32'd0;
        case (ALU_op)
            ALU_ADD:  out = A + B;
            ALU_SUB:  out = A - B;
            ALU_SLL:  out = A << w_shamt;
            ALU_SLT:  out = {31'd0, $signed(A) < $signed(B)};
            ALU_SLTU: out = {31'd0, A < B};
            ALU_XOR:  out = A ^ B;
            ALU_SRL:  out = A >> w_shamt;
            ALU_SRA:  out = $unsigned($signed(A) >>> w_shamt);
            ALU_OR:   out = A | B;
            ALU_AND:  out = A & B;
            default:  out = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_arb.sv
//------------------------------------------------------------------------------
// Module : alu_share_arb
// Brief  : Two-requester arbiter sharing one ALU, with a one-entry response
//          register. Optional opcode check enabled by ALU_ARB_OPCHK_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int OP_W      = 4,
    parameter int PRIO_MODE = 0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [OP_W-1:0]   r0_op,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [OP_W-1:0]   r1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam logic c_FIXED_PRIO = (PRIO_MODE != 0);

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q,    rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rr_last_q,   rr_last_d;

    logic              w_out_free;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    alu_req_t          w_req;
    logic [31:0]       w_alu_out;

    // rr_last_q=1 means r1 won last, so r0 takes the next contest.
    assign w_out_free = !rsp_valid_q || rsp_ready;
    assign w_grant0   = r0_valid && (!r1_valid || c_FIXED_PRIO || rr_last_q);
    assign w_grant1   = r1_valid && !w_grant0;
    assign w_accept   = (w_grant0 || w_grant1) && w_out_free;

    assign r0_ready   = w_grant0 && w_out_free;
    assign r1_ready   = w_grant1 && w_out_free;

    always_comb begin
        w_req = w_grant1 ? '{a: r1_a, b: r1_b, op: r1_op}
                         : '{a: r0_a, b: r0_b, op: r0_op};
    end

    alu_share_arb_alu u_alu (
        .A      (w_req.a),
        .B      (w_req.b),
        .ALU_op (w_req.op),
        .out    (w_alu_out)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rr_last_d   = rr_last_q;
        if (w_accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = w_grant1;
            rsp_data_d  = w_alu_out;
            rr_last_d   = w_grant1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rr_last_q   <= 1'b1;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_OPCHK_EN
    logic rsp_err_q, rsp_err_d;

    always_comb begin
        rsp_err_d = rsp_err_q;
        if (w_accept) begin
            rsp_err_d = (w_req.op > 4'(ALU_OP_MAX));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
//------------------------------------------------------------------------------
// Module : tb_alu_share_arb
// Brief  : Bench for alu_share_arb, round-robin and fixed-priority instances
//          driven by the same stimulus. Honours ALU_ARB_OPCHK_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid, rsp_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [3:0]  r0_op, r1_op;

    logic        o_r0_ready [2];
    logic        o_r1_ready [2];
    logic        o_rsp_valid[2];
    logic        o_rsp_id   [2];
    logic [31:0] o_rsp_data [2];
    logic        o_rsp_err  [2];

    // Reference state per instance: index 0 round-robin, 1 fixed priority
    logic        m_v   [2];
    logic        m_id  [2];
    logic [31:0] m_data[2];
    logic        m_err [2];
    logic        m_last[2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.DATA_W(32), .OP_W(4), .PRIO_MODE(0)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(o_r0_ready[0]), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(o_r1_ready[0]), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .rsp_valid(o_rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_id(o_rsp_id[0]),
        .rsp_data(o_rsp_data[0]), .rsp_err(o_rsp_err[0])
    );

    alu_share_arb #(.DATA_W(32), .OP_W(4), .PRIO_MODE(1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(o_r0_ready[1]), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(o_r1_ready[1]), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .rsp_valid(o_rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_id(o_rsp_id[1]),
        .rsp_data(o_rsp_data[1]), .rsp_err(o_rsp_err[1])
    );

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: return $unsigned($signed(a) >>> sh);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_err(input logic [3:0] op);
`ifdef ALU_ARB_OPCHK_EN
        return (op > 4'd9);
`else
        return (op != op);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_v[m] = 1'b0; m_id[m] = 1'b0; m_data[m] = 32'd0; m_err[m] = 1'b0; m_last[m] = 1'b1;
        end
    endtask

    // Compare all outputs against the model, then advance the model by one edge.
    task automatic compare_and_step();
        for (int m = 0; m < 2; m++) begin
            logic free, win1, any, exp0, exp1;
            free = !m_v[m] || rsp_ready;
            any  = r0_valid || r1_valid;
            if (r0_valid && r1_valid) win1 = (m == 0) ? !m_last[m] : 1'b0;
            else                      win1 = r1_valid;
            exp0 = any && !win1 && free;
            exp1 = any && win1 && free;
            chk($sformatf("m%0d r0_ready", m), 32'(o_r0_ready[m]), 32'(exp0));
            chk($sformatf("m%0d r1_ready", m), 32'(o_r1_ready[m]), 32'(exp1));
            chk($sformatf("m%0d rsp_valid", m), 32'(o_rsp_valid[m]), 32'(m_v[m]));
            if (m_v[m]) begin
                chk($sformatf("m%0d rsp_id", m), 32'(o_rsp_id[m]), 32'(m_id[m]));
                chk($sformatf("m%0d rsp_data", m), o_rsp_data[m], m_data[m]);
                chk($sformatf("m%0d rsp_err", m), 32'(o_rsp_err[m]), 32'(m_err[m]));
            end
            if (exp0 || exp1) begin
                m_v[m]    = 1'b1;
                m_id[m]   = win1;
                m_last[m] = win1;
                m_data[m] = win1 ? ref_alu(r1_a, r1_b, r1_op) : ref_alu(r0_a, r0_b, r0_op);
                m_err[m]  = win1 ? ref_err(r1_op) : ref_err(r0_op);
            end else if (rsp_ready) begin
                m_v[m] = 1'b0;
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        compare_and_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op0, input logic v1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic [3:0] op1, input logic rr);
        r0_valid = v0; r0_a = a0; r0_b = b0; r0_op = op0;
        r1_valid = v1; r1_a = a1; r1_b = b1; r1_op = op1;
        rsp_ready = rr;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #7;
        chk("reset rsp_valid", 32'(o_rsp_valid[0]), 32'd0);
        chk("reset rsp_id",    32'(o_rsp_id[0]),    32'd0);
        chk("reset rsp_data",  o_rsp_data[0],       32'd0);
        chk("reset rsp_err",   32'(o_rsp_err[0]),   32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // r0 alone: ADD 5+7
        drive(1, 5, 7, 0, 0, 0, 0, 0, 1);
        chk("t1 r0_ready", 32'(o_r0_ready[0]), 32'd1);
        run_cycle();
        chk("t1 rsp_valid", 32'(o_rsp_valid[0]), 32'd1);
        chk("t1 rsp_id",    32'(o_rsp_id[0]),    32'd0);
        chk("t1 rsp_data",  o_rsp_data[0],       32'd12);

        // Both valid: round-robin alternates starting with r1 (r0 just won)
        for (int k = 0; k < 8; k++) begin
            drive(1, 32'(k), 32'd100, 0, 1, 32'(k), 32'd200, 0, 1);
            run_cycle();
            chk("t2 rr rsp_id", 32'(o_rsp_id[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2 fp rsp_id", 32'(o_rsp_id[1]), 32'd0);
        end

        // r1 SRA, then stall the response register
        drive(0, 0, 0, 0, 1, 32'h8000_0000, 32'd4, 4'd7, 1);
        run_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'd10, 32'd3, 1, 0, 0, 0, 0, 0);
            chk("t3 r0_ready stall", 32'(o_r0_ready[0]), 32'd0);
            chk("t3 r1_ready stall", 32'(o_r1_ready[0]), 32'd0);
            run_cycle();
            chk("t3 rsp_data held", o_rsp_data[0], 32'hF800_0000);
            chk("t3 rsp_id held",   32'(o_rsp_id[0]), 32'd1);
        end
        drive(1, 32'd10, 32'd3, 1, 0, 0, 0, 0, 1);
        chk("t3 drain+accept r0_ready", 32'(o_r0_ready[0]), 32'd1);
        run_cycle();
        chk("t3 next rsp_data", o_rsp_data[0], 32'd7);

        // Fixed priority: r0 always wins
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'd1, 32'd2, 8, 1, 32'd4, 32'd8, 8, 1);
            chk("t4 fp r0_ready", 32'(o_r0_ready[1]), 32'd1);
            chk("t4 fp r1_ready", 32'(o_r1_ready[1]), 32'd0);
            run_cycle();
        end

        // Undefined opcode
        drive(1, 32'hDEAD_BEEF, 32'h1234, 4'd12, 0, 0, 0, 0, 1);
        run_cycle();
        chk("t6 rsp_data", o_rsp_data[0], 32'd0);
`ifdef ALU_ARB_OPCHK_EN
        chk("t6 rsp_err", 32'(o_rsp_err[0]), 32'd1);
`else
        chk("t6 rsp_err", 32'(o_rsp_err[0]), 32'd0);
`endif

        // Asynchronous reset while a response is pending
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5 pre-reset rsp_valid", 32'(o_rsp_valid[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5 rr rsp_valid async", 32'(o_rsp_valid[0]), 32'd0);
        chk("t5 fp rsp_valid async", 32'(o_rsp_valid[1]), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 32'd3, 32'd3, 0, 1, 32'd4, 32'd4, 0, 1);
        chk("t5 first contest r0_ready", 32'(o_r0_ready[0]), 32'd1);
        chk("t5 first contest r1_ready", 32'(o_r1_ready[0]), 32'd0);
        run_cycle();

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            logic [31:0] b0, b1;
            b0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            drive($urandom_range(0, 3) != 0, $urandom, b0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom, b1, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2) != 0);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
